// File: rtl/swervolf_board_io.sv
`default_nettype none
// ============================================================================
// Module   : swervolf_board_io
// Purpose  : Board I/O conditioning between board pins and swervolf_core.
//            - NUM_SW switches: 2-flop synchronised, per-bit debounced.
//            - NUM_LED LEDs: two register stages.
//            - NUM_UART TX sources: synchronised, glitch-free switch-over
//              that only happens once old and new lines have both idled.
// Options  : SWERVOLF_LED_PWM_EN adds i_led_duty and an 8-bit PWM dimmer.
// Revision : 1.0 - initial release
// ============================================================================
module swervolf_board_io #(
  parameter int NUM_SW           = 4,
  parameter int NUM_LED          = 16,
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int NUM_UART         = 2,
  parameter int UART_IDLE_CYCLES = 2604,
  localparam int SELW            = $clog2(NUM_UART)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NUM_SW-1:0]   i_sw,
  output logic [NUM_SW-1:0]   o_sw,
  output logic                o_sw_chg,
  input  logic [NUM_LED-1:0]  i_led,
`ifdef SWERVOLF_LED_PWM_EN
  input  logic [7:0]          i_led_duty,
`endif
  output logic [NUM_LED-1:0]  o_led,
  input  logic [NUM_UART-1:0] i_uart_tx,
  input  logic [SELW-1:0]     i_uart_sel,
  output logic                o_uart_tx,
  output logic [SELW-1:0]     o_uart_sel
);

  // --------------------------------------------------------------------------
  // Switch path
  // --------------------------------------------------------------------------
  logic [NUM_SW-1:0] r_sw_meta;
  logic [NUM_SW-1:0] r_sw_sync;
  logic [NUM_SW-1:0] r_sw_prev;
  logic [NUM_SW-1:0] w_sw_flip;

  // Two-flop synchroniser for the raw switch pins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= i_sw;
      r_sw_sync <= r_sw_meta;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_db_bypass
      // No filtering: follow the synchronised level one cycle later
      assign w_sw_flip = r_sw_sync ^ o_sw;
    end else begin : g_db_count
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      for (genvar i = 0; i < NUM_SW; i++) begin : g_sw_bit
        logic [CNT_W-1:0] r_db_cnt;
        logic             w_differs;

        assign w_differs    = r_sw_sync[i] ^ o_sw[i];
        assign w_sw_flip[i] = w_differs && (r_db_cnt == C_DB_LAST);

        // Count consecutive cycles the synced level disagrees with o_sw
        always_ff @(posedge clk or negedge rstn) begin
          if (!rstn) begin
            r_db_cnt <= '0;
          end else if (!w_differs || (r_db_cnt == C_DB_LAST)) begin
            r_db_cnt <= '0;
          end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
          end
        end
      end
    end
  endgenerate

  // Accepted switch levels plus a one-cycle change pulse trailing the update
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_sw      <= '0;
      r_sw_prev <= '0;
      o_sw_chg  <= 1'b0;
    end else begin
      o_sw      <= o_sw ^ w_sw_flip;
      r_sw_prev <= o_sw;
      o_sw_chg  <= |(o_sw ^ r_sw_prev);
    end
  end

  // --------------------------------------------------------------------------
  // LED path
  // --------------------------------------------------------------------------
  logic [NUM_LED-1:0] r_led_stage1;

`ifdef SWERVOLF_LED_PWM_EN
  logic [7:0] r_pwm_cnt;
  logic       w_pwm_on;

  // Full duty is forced on so 255 does not leave a one-count dark slot
  assign w_pwm_on = (i_led_duty == 8'hFF) || (r_pwm_cnt < i_led_duty);

  // Free-running PWM phase counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end
  end

  // Two LED stages; the second stage applies the dimming gate
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led_stage1 <= '0;
      o_led        <= '0;
    end else begin
      r_led_stage1 <= i_led;
      o_led        <= r_led_stage1 & {NUM_LED{w_pwm_on}};
    end
  end
`else
  // Two LED stages, straight through
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_led_stage1 <= '0;
      o_led        <= '0;
    end else begin
      r_led_stage1 <= i_led;
      o_led        <= r_led_stage1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // UART TX mux
  // --------------------------------------------------------------------------
  localparam int IDLE_W = (UART_IDLE_CYCLES > 1) ? $clog2(UART_IDLE_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] C_IDLE_LAST = IDLE_W'(UART_IDLE_CYCLES - 1);
  localparam logic [SELW:0]     C_NUM_UART  = (SELW + 1)'(NUM_UART);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } uart_state_t;

  logic [NUM_UART-1:0] r_tx_meta;
  logic [NUM_UART-1:0] r_tx_sync;
  logic [SELW-1:0]     r_sel_meta;
  logic [SELW-1:0]     r_sel_sync;
  uart_state_t         r_state;
  uart_state_t         w_state_next;
  logic [SELW-1:0]     r_active;
  logic [SELW-1:0]     w_active_next;
  logic [SELW-1:0]     r_target;
  logic [SELW-1:0]     w_target_next;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [IDLE_W-1:0]   w_idle_cnt_next;
  logic                w_sel_valid;
  logic                w_both_idle;

  assign w_sel_valid = ({1'b0, r_sel_sync} < C_NUM_UART);
  assign w_both_idle = r_tx_sync[r_active] & r_tx_sync[r_target];
  assign o_uart_sel  = r_active;

  // Synchronisers for TX lines (idle high) and the source request
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tx_meta  <= '1;
      r_tx_sync  <= '1;
      r_sel_meta <= '0;
      r_sel_sync <= '0;
    end else begin
      r_tx_meta  <= i_uart_tx;
      r_tx_sync  <= r_tx_meta;
      r_sel_meta <= i_uart_sel;
      r_sel_sync <= r_sel_meta;
    end
  end

  // Switch-over state, active/target source and idle run length
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_RUN;
      r_active   <= '0;
      r_target   <= '0;
      r_idle_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_active   <= w_active_next;
      r_target   <= w_target_next;
      r_idle_cnt <= w_idle_cnt_next;
    end
  end

  // Next-state: hold off a switch until both lines idle for the full window
  always_comb begin
    w_state_next    = r_state;
    w_active_next   = r_active;
    w_target_next   = r_target;
    w_idle_cnt_next = r_idle_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_sel_valid && (r_sel_sync != r_active)) begin
          w_target_next   = r_sel_sync;
          w_idle_cnt_next = '0;
          w_state_next    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (!w_sel_valid || (r_sel_sync == r_active)) begin
          w_idle_cnt_next = '0;
          w_state_next    = ST_RUN;
        end else if (r_sel_sync != r_target) begin
          w_target_next   = r_sel_sync;
          w_idle_cnt_next = '0;
        end else if (!w_both_idle) begin
          w_idle_cnt_next = '0;
        end else if (r_idle_cnt == C_IDLE_LAST) begin
          w_active_next   = r_target;
          w_idle_cnt_next = '0;
          w_state_next    = ST_RUN;
        end else begin
          w_idle_cnt_next = r_idle_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_RUN;
      end
    endcase
  end

  // Registered TX output from the currently active source
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_uart_tx <= 1'b1;
    end else begin
      o_uart_tx <= r_tx_sync[r_active];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_swervolf_board_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_swervolf_board_io
// Purpose  : Self-checking bench for swervolf_board_io against a cycle-level
//            behavioural model (delays, run lengths, request bookkeeping).
//            Define SWERVOLF_LED_PWM_EN to also exercise the LED dimmer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_swervolf_board_io;

  localparam int NSW  = 4;
  localparam int NLED = 16;
  localparam int DB   = 8;
  localparam int NU   = 3;
  localparam int IDLE = 16;

  logic            clk = 1'b0;
  logic            rstn;
  logic [NSW-1:0]  i_sw;
  logic [NSW-1:0]  o_sw;
  logic            o_sw_chg;
  logic [NLED-1:0] i_led;
  logic [NLED-1:0] o_led;
  logic [NU-1:0]   i_uart_tx;
  logic [1:0]      i_uart_sel;
  logic            o_uart_tx;
  logic [1:0]      o_uart_sel;
`ifdef SWERVOLF_LED_PWM_EN
  logic [7:0]      i_led_duty;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  swervolf_board_io #(
    .NUM_SW(NSW), .NUM_LED(NLED), .DEBOUNCE_CYCLES(DB),
    .NUM_UART(NU), .UART_IDLE_CYCLES(IDLE)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_sw(i_sw), .o_sw(o_sw), .o_sw_chg(o_sw_chg),
    .i_led(i_led),
`ifdef SWERVOLF_LED_PWM_EN
    .i_led_duty(i_led_duty),
`endif
    .o_led(o_led),
    .i_uart_tx(i_uart_tx), .i_uart_sel(i_uart_sel),
    .o_uart_tx(o_uart_tx), .o_uart_sel(o_uart_sel)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model state ----------------
  logic [NSW-1:0]  sw_p1, sw_p2, m_sw, m_sw_prev;
  logic            m_chg;
  int              run_len [NSW];
  logic [NLED-1:0] led_p1, m_led;
  logic [NU-1:0]   tx_p1, tx_p2;
  int              sel_p1, sel_p2;
  logic            m_tx;
  int              m_active, m_tgt, m_run;
  bit              m_pend;
  int              pwm_phase;

  task automatic model_reset();
    sw_p1 = '0; sw_p2 = '0; m_sw = '0; m_sw_prev = '0; m_chg = 1'b0;
    for (int i = 0; i < NSW; i++) run_len[i] = 0;
    led_p1 = '0; m_led = '0;
    tx_p1 = '1; tx_p2 = '1; sel_p1 = 0; sel_p2 = 0;
    m_tx = 1'b1; m_active = 0; m_tgt = 0; m_run = 0; m_pend = 1'b0;
    pwm_phase = 0;
  endtask

  // One clock: advance the model on the rising edge, return at the falling edge
  task automatic tick();
    logic [NSW-1:0] sw_s;
    logic [NU-1:0]  tx_s;
    int             sel_s;
    bit             lit;
    @(posedge clk);
    // Inputs reach the logic after two synchroniser stages
    sw_s  = sw_p2;  sw_p2  = sw_p1;  sw_p1  = i_sw;
    tx_s  = tx_p2;  tx_p2  = tx_p1;  tx_p1  = i_uart_tx;
    sel_s = sel_p2; sel_p2 = sel_p1; sel_p1 = int'(i_uart_sel);
    // Switches: accept a level after DB consecutive disagreeing cycles
    m_chg = (m_sw != m_sw_prev);
    m_sw_prev = m_sw;
    for (int i = 0; i < NSW; i++) begin
      if (sw_s[i] != m_sw[i]) begin
        run_len[i] = run_len[i] + 1;
        if (run_len[i] == DB) begin
          m_sw[i] = sw_s[i];
          run_len[i] = 0;
        end
      end else begin
        run_len[i] = 0;
      end
    end
    // LEDs: two-cycle delay, optionally gated by duty
    lit = 1'b1;
`ifdef SWERVOLF_LED_PWM_EN
    lit = (i_led_duty == 8'd255) || (pwm_phase < int'(i_led_duty));
    pwm_phase = (pwm_phase + 1) % 256;
`endif
    m_led = lit ? led_p1 : '0;
    led_p1 = i_led;
    // UART: output old active source; a valid foreign request must see
    // IDLE consecutive cycles of both lines high before taking over
    m_tx = tx_s[m_active];
    if (sel_s < NU && sel_s != m_active) begin
      if (!m_pend || sel_s != m_tgt) begin
        m_pend = 1'b1; m_tgt = sel_s; m_run = 0;
      end else if (tx_s[m_active] && tx_s[m_tgt]) begin
        m_run = m_run + 1;
        if (m_run == IDLE) begin
          m_active = m_tgt; m_pend = 1'b0; m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end else begin
      m_pend = 1'b0; m_run = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rstn = 1'b0; i_sw = '0; i_led = '0; i_uart_tx = '1; i_uart_sel = '0;
`ifdef SWERVOLF_LED_PWM_EN
    i_led_duty = 8'd255;
`endif
    model_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (o_sw !== 4'b0000) begin n_fail++; $display("FAIL reset_sw got=%b exp=0000", o_sw); end
    n_checks++; if (o_sw_chg !== 1'b0) begin n_fail++; $display("FAIL reset_chg got=%b exp=0", o_sw_chg); end
    n_checks++; if (o_led !== 16'h0000) begin n_fail++; $display("FAIL reset_led got=%h exp=0000", o_led); end
    n_checks++; if (o_uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got=%b exp=1", o_uart_tx); end
    n_checks++; if (o_uart_sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", o_uart_sel); end
    rstn = 1'b1;
  endtask

  task automatic test_debounce();
    int pulses;
    i_sw = 4'b0001;                         // raw edge lands before edge 1
    pulses = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      n_checks++;
      if (o_sw !== ((c >= DB + 2) ? 4'b0001 : 4'b0000)) begin
        n_fail++; $display("FAIL db_latency cyc=%0d got=%b", c, o_sw);
      end
      n_checks++;
      if (o_sw_chg !== ((c == DB + 3) ? 1'b1 : 1'b0)) begin
        n_fail++; $display("FAIL db_chg cyc=%0d got=%b", c, o_sw_chg);
      end
      if (o_sw_chg === 1'b1) pulses++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL db_pulses got=%0d exp=1", pulses); end
    // Glitch on bit 2 shorter than the debounce window
    i_sw = 4'b0101;
    repeat (5) tick();
    i_sw = 4'b0001;
    for (int c = 0; c < 15; c++) begin
      tick();
      n_checks++;
      if (o_sw !== 4'b0001 || o_sw_chg !== 1'b0 || o_sw !== m_sw) begin
        n_fail++; $display("FAIL db_glitch cyc=%0d got=%b chg=%b exp=0001", c, o_sw, o_sw_chg);
      end
    end
  endtask

  task automatic test_led();
    i_led = 16'hA5C3;
    tick();
    n_checks++; if (o_led !== 16'h0000) begin n_fail++; $display("FAIL led_lat1 got=%h exp=0000", o_led); end
    tick();
    n_checks++; if (o_led !== 16'hA5C3) begin n_fail++; $display("FAIL led_lat2 got=%h exp=a5c3", o_led); end
    #2 rstn = 1'b0;
    model_reset();
    #1;
    n_checks++; if (o_led !== 16'h0000) begin n_fail++; $display("FAIL led_async_rst got=%h exp=0000", o_led); end
    n_checks++; if (o_sw !== 4'b0000) begin n_fail++; $display("FAIL sw_async_rst got=%b exp=0000", o_sw); end
    @(negedge clk);
    i_led = '0; i_sw = '0;
    rstn = 1'b1;
  endtask

  task automatic test_uart_switch();
    i_uart_tx = '1; i_uart_sel = 2'd0;
    do_reset();
    i_uart_sel = 2'd1;
    for (int t = 0; t < 48; t++) begin      // source 0 toggles every 4 cycles
      i_uart_tx[0] = ((t / 4) % 2 == 0);
      tick();
      n_checks++;
      if (o_uart_sel !== 2'd0 || o_uart_tx !== m_tx) begin
        n_fail++; $display("FAIL uart_busy t=%0d sel=%0d tx=%b exp_tx=%b", t, o_uart_sel, o_uart_tx, m_tx);
      end
    end
    i_uart_tx[0] = 1'b0;
    tick();
    i_uart_tx = '1;                          // both lines idle from here
    for (int c = 1; c <= 26; c++) begin
      tick();
      if (c == 2 + IDLE - 1) begin
        n_checks++; if (o_uart_sel !== 2'd0) begin n_fail++; $display("FAIL uart_early got=%0d exp=0", o_uart_sel); end
      end
      if (c == 2 + IDLE) begin
        n_checks++; if (o_uart_sel !== 2'd1) begin n_fail++; $display("FAIL uart_switch got=%0d exp=1", o_uart_sel); end
      end
      if (c >= 4) begin
        n_checks++; if (o_uart_tx !== 1'b1) begin n_fail++; $display("FAIL uart_glitch c=%0d got=%b exp=1", c, o_uart_tx); end
      end
    end
  endtask

  task automatic test_uart_retarget();
    i_uart_tx = '1; i_uart_sel = 2'd0;
    do_reset();
    i_uart_sel = 2'd1;
    repeat (8) tick();
    i_uart_sel = 2'd2;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 2 + IDLE) begin
        n_checks++; if (o_uart_sel !== 2'd0) begin n_fail++; $display("FAIL retgt_early got=%0d exp=0", o_uart_sel); end
      end
      if (c == 3 + IDLE) begin
        n_checks++; if (o_uart_sel !== 2'd2) begin n_fail++; $display("FAIL retgt_switch got=%0d exp=2", o_uart_sel); end
      end
    end
    i_uart_sel = 2'd0;
    repeat (5) tick();
    i_uart_sel = 2'd3;                       // out of range: withdraws the request
    for (int c = 0; c < 40; c++) begin
      tick();
      n_checks++;
      if (o_uart_sel !== 2'd2 || o_uart_sel !== 2'(m_active)) begin
        n_fail++; $display("FAIL uart_oor c=%0d got=%0d exp=2", c, o_uart_sel);
      end
    end
  endtask

  task automatic test_random();
    int hold;
    i_uart_tx = '1; i_uart_sel = 2'd0; i_sw = '0; i_led = '0;
    do_reset();
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        i_sw = 4'($urandom);
        hold = $urandom_range(1, 20);
      end
      hold--;
      i_led = 16'($urandom);
      for (int u = 0; u < NU; u++) i_uart_tx[u] = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 29) == 0) i_uart_sel = 2'($urandom_range(0, 3));
      tick();
      n_checks++;
      if (o_sw !== m_sw || o_sw_chg !== m_chg) begin
        n_fail++; $display("FAIL rnd_sw c=%0d got=%b/%b exp=%b/%b", c, o_sw, o_sw_chg, m_sw, m_chg);
      end
      n_checks++;
      if (o_led !== m_led) begin n_fail++; $display("FAIL rnd_led c=%0d got=%h exp=%h", c, o_led, m_led); end
      n_checks++;
      if (o_uart_tx !== m_tx || o_uart_sel !== 2'(m_active)) begin
        n_fail++; $display("FAIL rnd_uart c=%0d got=%b/%0d exp=%b/%0d", c, o_uart_tx, o_uart_sel, m_tx, m_active);
      end
    end
  endtask

`ifdef SWERVOLF_LED_PWM_EN
  task automatic test_pwm();
    int duties [3] = '{64, 0, 255};
    int on_cnt;
    i_led = '1;
    for (int d = 0; d < 3; d++) begin
      i_led_duty = 8'(duties[d]);
      repeat (3) tick();
      on_cnt = 0;
      for (int c = 0; c < 256; c++) begin
        tick();
        if (o_led === 16'hFFFF) on_cnt++;
        n_checks++;
        if (o_led !== m_led) begin n_fail++; $display("FAIL pwm_led duty=%0d got=%h exp=%h", duties[d], o_led, m_led); end
      end
      n_checks++;
      if (on_cnt != duties[d] + ((duties[d] == 255) ? 1 : 0)) begin
        n_fail++; $display("FAIL pwm_ratio duty=%0d got=%0d on-cycles", duties[d], on_cnt);
      end
    end
    i_led_duty = 8'd255;
  endtask
`endif

  initial begin
    test_reset();
    test_debounce();
    test_led();
    test_uart_switch();
    test_uart_retarget();
    test_random();
`ifdef SWERVOLF_LED_PWM_EN
    test_pwm();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/swervolf_board_io.md
Name: swervolf_board_io

Overview:
Parametrised board I/O conditioning block for SweRVolf board toplevels, placed between board pins and swervolf_core GPIO/UART.
- Switches: synchronised and debounced (NUM_SW of them).
- LEDs: registered, NUM_LED of them.
- UART TX: glitch-free selection among NUM_UART transmitters (for example CPU and LiteDRAM console). A switch-over takes effect only when both lines have been idle.
- Generalises the fixed 4-switch / 16-LED / 2-UART toplevel logic so every board target reuses one block.

Parameters:
- NUM_SW, 4, number of switch inputs.
- NUM_LED, 16, number of LED outputs.
- DEBOUNCE_CYCLES, 250000, cycles a synced switch level must be stable before it is accepted. 0 = debounce bypassed.
- NUM_UART, 2, number of UART TX sources (>=2).
- UART_IDLE_CYCLES, 2604, consecutive cycles both old and new TX lines must be high before a switch-over. Default is 1 bit time at 9600 baud, 25 MHz.
- SELW, $clog2(NUM_UART), selector width (derived, not overridden).

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- i_sw  in  NUM_SW  raw switch pins, asynchronous.
- o_sw  out  NUM_SW  debounced switch levels.
- o_sw_chg  out  1  one-cycle pulse when any o_sw bit changes.
- i_led  in  NUM_LED  LED request from GPIO, clk domain.
- o_led  out  NUM_LED  LED pins.
- i_uart_tx  in  NUM_UART  TX lines, asynchronous to clk.
- i_uart_sel  in  SELW  requested TX source, asynchronous.
- o_uart_tx  out  1  selected TX line.
- o_uart_sel  out  SELW  currently active source.

Behaviour:

Reset values (all flops async-cleared on rstn low):
- o_sw=0, o_sw_chg=0, o_led=0.
- o_uart_tx=1 (idle high), o_uart_sel=0.
- Switch and sel synchronisers reset to 0; TX synchronisers reset to 1.

Switch path:
- 2-flop synchroniser per bit, then a per-bit counter of width $clog2(DEBOUNCE_CYCLES+1).
- synced bit == o_sw bit: counter cleared.
- Otherwise the counter increments. On the cycle it equals DEBOUNCE_CYCLES-1, o_sw bit flips and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Latency from a stable raw edge to o_sw: 2+DEBOUNCE_CYCLES cycles.
- DEBOUNCE_CYCLES=0: o_sw = synced value, latency 3.
- o_sw_chg is high exactly in the cycle after o_sw changes, once per change event. Simultaneous bit changes give one pulse.

LED path:
- Two register stages; o_led follows i_led with 2-cycle latency.

UART mux:
- Every i_uart_tx bit and i_uart_sel pass through 2-flop synchronisers.
- o_uart_tx is registered: tx_sync[active].
- Latency from input to o_uart_tx: 3 cycles.
- A synced sel >= NUM_UART is treated as "no request" (equal to active).

UART mux FSM:
- RUN:
  - Output = active source.
  - If synced sel != active and is in range: latch target, clear idle counter, go to PEND.
- PEND:
  - Output stays on the old active source.
  - Idle counter increments while tx_sync[active] and tx_sync[target] are both 1. Any 0 on either line clears it.
  - Counter reaching UART_IDLE_CYCLES-1: active <= target, counter cleared, go to RUN. The new source drives o_uart_tx from the next cycle, and o_uart_sel updates in the same cycle as active.
  - sel returns to active during PEND: go to RUN, no switch.
  - sel changes to a different third value during PEND: target updated, counter cleared, stay in PEND.
- Counter width: $clog2(UART_IDLE_CYCLES+1).
- Reset mid-PEND: returns to RUN with active=0.

Optional Feature:
SWERVOLF_LED_PWM_EN
- Defined:
  - Adds input i_led_duty [7:0] and an 8-bit free-running counter pwm_cnt (reset 0, wraps 255->0).
  - o_led[i] = led_stage2[i] & (pwm_cnt < i_led_duty).
  - i_led_duty=0 keeps all LEDs off; duty=128 gives 50% on.
  - i_led_duty=255 is forced fully on.
  - o_led is registered, so total latency stays 2.
- Not defined: port absent, no counter, o_led = led_stage2.

Test Plan:
1. Reset released, DEBOUNCE_CYCLES=8, i_sw=4'b0001 held -> o_sw=4'b0001 exactly 10 cycles after the raw edge; o_sw_chg pulses once.
2. i_sw[2] pulses high for 5 cycles (DEBOUNCE_CYCLES=8) -> o_sw stays 0, no o_sw_chg.
3. i_led=16'hA5C3 -> o_led=16'hA5C3 two cycles later; rstn low asynchronously -> o_led=0 immediately.
4. UART_IDLE_CYCLES=16, sel 0->1 while source 0 toggles every 4 cycles -> stays PEND, o_uart_sel=0. When both lines are held high, the switch occurs after exactly 16 idle cycles, o_uart_sel=1, and o_uart_tx shows no low glitch.
5. NUM_UART=3, PEND target 1, sel changed to 2 mid-count -> counter restarts and the final o_uart_sel=2. sel=3 (out of range) -> no request, stays RUN.
6. SWERVOLF_LED_PWM_EN, i_led=all-ones -> duty=64 gives 64/256 on per LED; duty=0 gives all off; duty=255 gives constantly on.
